// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind spi_slave: decodes the SPI byte stream into
// register-bus reads/writes with optional address auto-increment, framed by slave select.
module spi_reg_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter bit          AUTO_INC   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [DATA_WIDTH-1:0] rx_buffer,
    input  logic                  rx_dv,
    output logic [DATA_WIDTH-1:0] tx_buffer,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  active,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRreq,
        StRload,
        StRwait
    } state_e;

    state_e                state_q, state_d;
    logic                  ss_meta_q, ss_s_q, ss_prev_q;
    logic                  active_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  we_pend_q, we_pend_d;
    logic                  re_pend_q, re_pend_d;
    logic                  wr_pend_q, wr_pend_d;
    logic                  ovr_q, ovr_d;
    logic                  ss_fall, ss_rise;

    assign ss_fall = ss_prev_q & ~ss_s_q;
    assign ss_rise = ~ss_prev_q & ss_s_q;

    // Strobes are scheduled one cycle ahead; a deselect in the issuing cycle suppresses them.
    assign reg_we    = we_pend_q & ~ss_rise;
    assign reg_re    = re_pend_q & ~ss_rise;
    assign wr        = wr_pend_q & ~ss_rise;
    // Read data arrives in the wr cycle, so forward it while also capturing it for later.
    assign tx_buffer = wr ? reg_rdata : tx_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign active    = active_q;
    assign overrun   = ovr_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        we_pend_d = 1'b0;
        re_pend_d = 1'b0;
        wr_pend_d = 1'b0;
        ovr_d     = ovr_q;

        if (wr) begin
            tx_d = reg_rdata;
        end
        if (AUTO_INC && (reg_we || wr)) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        if (ss_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        ovr_d   = 1'b0;
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (rx_dv) begin
                        addr_d  = rx_buffer[ADDR_WIDTH-1:0];
                        state_d = rx_buffer[DATA_WIDTH-1] ? StRreq : StWdata;
                    end
                end
                StWdata: begin
                    if (rx_dv) begin
                        we_pend_d = 1'b1;
                        wdata_d   = rx_buffer;
                    end
                end
                StRreq: begin
                    re_pend_d = 1'b1;
                    state_d   = StRload;
                    if (rx_dv) begin
                        ovr_d = 1'b1;
                    end
                end
                StRload: begin
                    wr_pend_d = 1'b1;
                    state_d   = StRwait;
                    if (rx_dv) begin
                        ovr_d = 1'b1;
                    end
                end
                StRwait: begin
                    if (rx_dv) begin
                        state_d = StRreq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta_q <= 1'b1;
            ss_s_q    <= 1'b1;
            ss_prev_q <= 1'b1;
            active_q  <= 1'b0;
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            we_pend_q <= 1'b0;
            re_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ss_meta_q <= ss;
            ss_s_q    <= ss_meta_q;
            ss_prev_q <= ss_s_q;
            active_q  <= ~ss_s_q;
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            we_pend_q <= we_pend_d;
            re_pend_q <= re_pend_d;
            wr_pend_q <= wr_pend_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of SPI transactions checked against hand-computed
// strobe logs, plus sequences for abort, overrun and mid-transaction reset.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst, ss, rx_dv;
    logic [7:0] rx_buffer, reg_rdata;
    logic [7:0] tx_buffer, reg_wdata, h_tx_buffer, h_reg_wdata;
    logic [6:0] reg_addr, h_reg_addr;
    logic       wr, reg_we, reg_re, active, overrun;
    logic       h_wr, h_reg_we, h_reg_re, h_active, h_overrun;

    spi_reg_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst(rst), .ss(ss), .rx_buffer(rx_buffer), .rx_dv(rx_dv),
        .tx_buffer(tx_buffer), .wr(wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .active(active),
        .overrun(overrun)
    );

    // Same stimulus, address held: only its write strobes are checked.
    spi_reg_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .AUTO_INC(1'b0)) dut_h (
        .clk(clk), .rst(rst), .ss(ss), .rx_buffer(rx_buffer), .rx_dv(rx_dv),
        .tx_buffer(h_tx_buffer), .wr(h_wr), .reg_addr(h_reg_addr), .reg_wdata(h_reg_wdata),
        .reg_we(h_reg_we), .reg_re(h_reg_re), .reg_rdata(reg_rdata), .active(h_active),
        .overrun(h_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: synchronous read, data valid the cycle after reg_re.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    logic [6:0] we_a[$], re_a[$], hw_a[$];
    logic [7:0] we_d[$], wr_d[$], hw_d[$];
    int         we_c[$], re_c[$], wr_c[$];
    int         excl_viol = 0;

    always @(negedge clk) begin
        if (reg_we) begin we_a.push_back(reg_addr); we_d.push_back(reg_wdata); we_c.push_back(cyc); end
        if (reg_re) begin re_a.push_back(reg_addr); re_c.push_back(cyc); end
        if (wr) begin wr_d.push_back(tx_buffer); wr_c.push_back(cyc); end
        if (h_reg_we) begin hw_a.push_back(h_reg_addr); hw_d.push_back(h_reg_wdata); end
        if (32'(reg_we) + 32'(reg_re) + 32'(wr) > 32'd1) excl_viol++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b, output int n);
        rx_buffer = b;
        rx_dv     = 1'b1;
        n         = cyc;
        step();
        rx_dv = 1'b0;
        steps(7);
    endtask

    task automatic frame_open();
        ss = 1'b0;
        steps(4);
    endtask

    task automatic frame_close();
        ss = 1'b1;
        steps(4);
    endtask

    task automatic clear_logs();
        we_a.delete(); we_d.delete(); we_c.delete();
        re_a.delete(); re_c.delete(); wr_d.delete(); wr_c.delete();
        hw_a.delete(); hw_d.delete();
    endtask

    typedef struct packed {
        bit              rd;
        int              nb;
        logic [3:0][7:0] byt;
        int              ne;
        logic [2:0][6:0] adr;
        logic [2:0][7:0] dat;
    } vec_t;

    function automatic vec_t mk(input bit rd, input int nb, input logic [7:0] b0, b1, b2, b3,
                                input int ne, input logic [6:0] a0, a1, a2,
                                input logic [7:0] d0, d1, d2);
        vec_t v;
        v.rd = rd; v.nb = nb; v.ne = ne;
        v.byt[0] = b0; v.byt[1] = b1; v.byt[2] = b2; v.byt[3] = b3;
        v.adr[0] = a0; v.adr[1] = a1; v.adr[2] = a2;
        v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2;
        return v;
    endfunction

    localparam int NV = 6;
    vec_t vt [NV];
    int   bc [4];
    int   dly [2];
    int   nd;

    initial begin
        // mem[i] = i ^ 0xC3, except addr 3 which holds 0x5C
        vt[0] = mk(1'b0, 2, 8'h05, 8'hA5, 8'h00, 8'h00, 1, 7'h05, 7'h00, 7'h00,
                   8'hA5, 8'h00, 8'h00);
        vt[1] = mk(1'b0, 4, 8'h10, 8'h11, 8'h22, 8'h33, 3, 7'h10, 7'h11, 7'h12,
                   8'h11, 8'h22, 8'h33);
        vt[2] = mk(1'b1, 1, 8'h83, 8'h00, 8'h00, 8'h00, 1, 7'h03, 7'h00, 7'h00,
                   8'h5C, 8'h00, 8'h00);
        vt[3] = mk(1'b1, 3, 8'hFF, 8'h00, 8'h00, 8'h00, 3, 7'h7F, 7'h00, 7'h01,
                   8'hBC, 8'hC3, 8'hC2);
        vt[4] = mk(1'b0, 3, 8'h7F, 8'hAA, 8'hBB, 8'h00, 2, 7'h7F, 7'h00, 7'h00,
                   8'hAA, 8'hBB, 8'h00);
        vt[5] = mk(1'b1, 2, 8'h85, 8'h00, 8'h00, 8'h00, 2, 7'h05, 7'h06, 7'h00,
                   8'hA5, 8'hC5, 8'h00);

        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[3]    = 8'h5C;
        reg_rdata = 8'h00;
        rst = 1'b1; ss = 1'b1; rx_dv = 1'b0; rx_buffer = 8'h00;
        steps(3);
        check("reset_outputs", 32'({reg_we, reg_re, wr, active, overrun, reg_addr, reg_wdata,
                                    tx_buffer}), 32'd0);
        rst = 1'b0;
        steps(3);
        check("idle_active", 32'(active), 32'd0);

        for (int i = 0; i < NV; i++) begin
            clear_logs();
            frame_open();
            for (int b = 0; b < vt[i].nb; b++) send_byte(vt[i].byt[b], bc[b]);
            frame_close();
            if (vt[i].rd) begin
                check($sformatf("v%0d_rd_we_count", i), 32'(we_a.size()), 32'd0);
                check($sformatf("v%0d_re_count", i), 32'(re_a.size()), 32'(vt[i].ne));
                check($sformatf("v%0d_wr_count", i), 32'(wr_d.size()), 32'(vt[i].ne));
                for (int k = 0; k < vt[i].ne && k < re_a.size(); k++) begin
                    check($sformatf("v%0d_re_addr%0d", i, k), 32'(re_a[k]), 32'(vt[i].adr[k]));
                    check($sformatf("v%0d_re_cyc%0d", i, k), 32'(re_c[k]), 32'(bc[k] + 2));
                end
                for (int k = 0; k < vt[i].ne && k < wr_d.size(); k++) begin
                    check($sformatf("v%0d_tx%0d", i, k), 32'(wr_d[k]), 32'(vt[i].dat[k]));
                    check($sformatf("v%0d_wr_cyc%0d", i, k), 32'(wr_c[k]), 32'(bc[k] + 3));
                end
            end else begin
                check($sformatf("v%0d_we_count", i), 32'(we_a.size()), 32'(vt[i].ne));
                check($sformatf("v%0d_wr_re_count", i), 32'(re_a.size() + wr_d.size()), 32'd0);
                for (int k = 0; k < vt[i].ne && k < we_a.size(); k++) begin
                    check($sformatf("v%0d_we_addr%0d", i, k), 32'(we_a[k]), 32'(vt[i].adr[k]));
                    check($sformatf("v%0d_we_data%0d", i, k), 32'(we_d[k]), 32'(vt[i].dat[k]));
                    check($sformatf("v%0d_we_cyc%0d", i, k), 32'(we_c[k]), 32'(bc[k + 1] + 1));
                end
                check($sformatf("v%0d_hold_count", i), 32'(hw_a.size()), 32'(vt[i].ne));
                for (int k = 0; k < vt[i].ne && k < hw_a.size(); k++) begin
                    check($sformatf("v%0d_hold_addr%0d", i, k), 32'(hw_a[k]),
                          32'(vt[i].byt[0][6:0]));
                    check($sformatf("v%0d_hold_data%0d", i, k), 32'(hw_d[k]),
                          32'(vt[i].dat[k]));
                end
            end
        end

        // Abort: deselect cancels a scheduled write (d=1) or drops the byte outright (d=2).
        dly[0] = 1; dly[1] = 2;
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            frame_open();
            send_byte(8'h40, nd);
            ss = 1'b1;
            steps(dly[j]);
            rx_buffer = 8'h77;
            rx_dv     = 1'b1;
            step();
            rx_dv = 1'b0;
            steps(6);
            check($sformatf("abort%0d_no_we", j), 32'(we_a.size()), 32'd0);
            check($sformatf("abort%0d_active", j), 32'(active), 32'd0);
            send_byte(8'h41, nd);
            send_byte(8'h99, nd);
            check($sformatf("abort%0d_ignored", j),
                  32'(we_a.size() + re_a.size() + wr_d.size()), 32'd0);
        end
        clear_logs();
        frame_open();
        send_byte(8'h40, nd);
        send_byte(8'h66, nd);
        frame_close();
        check("recover_we_count", 32'(we_a.size()), 32'd1);
        if (we_a.size() > 0) begin
            check("recover_we_addr", 32'(we_a[0]), 32'h40);
            check("recover_we_data", 32'(we_d[0]), 32'h66);
        end

        // Overrun: second byte lands while the fetch is still in flight.
        clear_logs();
        frame_open();
        rx_buffer = 8'h81;
        rx_dv     = 1'b1;
        step();
        rx_buffer = 8'h12;
        step();
        rx_dv = 1'b0;
        steps(6);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_one_fetch", 32'(re_a.size()), 32'd1);
        frame_close();
        check("overrun_sticky", 32'(overrun), 32'd1);
        frame_open();
        check("overrun_cleared", 32'(overrun), 32'd0);
        check("frame_active", 32'(active), 32'd1);

        // Reset lands just before the read's wr pulse would have been issued.
        rx_buffer = 8'h85;
        rx_dv     = 1'b1;
        step();
        rx_dv = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midreset_outputs", 32'({reg_we, reg_re, wr, active, overrun, reg_addr, reg_wdata,
                                       tx_buffer}), 32'd0);
        rst = 1'b0;
        ss  = 1'b1;
        steps(4);
        clear_logs();
        send_byte(8'h05, nd);
        send_byte(8'h5A, nd);
        check("post_reset_idle", 32'(we_a.size() + re_a.size() + wr_d.size()), 32'd0);

        check("strobe_exclusive", 32'(excl_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
